// File: rtl/uart_fifo_mmio_if.sv
// Data-bus bundle between the pipeline CPU (master) and the MMIO UART (slave).
// An access is a single-cycle MemRead or MemWrite strobe with Address/Write_data valid in that same cycle.
// There is no ready signal: the slave always accepts, and Read_data is valid combinationally during the strobe.
interface uart_fifo_mmio_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (output MemRead, MemWrite, Address, Write_data, input Read_data);
    modport slave  (input MemRead, MemWrite, Address, Write_data, output Read_data);
endinterface

// File: rtl/uart_fifo_mmio.sv
// MMIO UART with TX/RX FIFOs, programmable divisor, sticky error flags and a level irq.
// Optional even parity is enabled with the UART_PARITY_EN macro; the default build is 8N1.
module uart_fifo_mmio #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_fifo_mmio_if.slave  bus,
    input  logic             Rx_Serial,
    output logic             Tx_Serial,
    output logic             irq,
    output logic [2:0]       tx_state_o,
    output logic [2:0]       rx_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic sel_txd, sel_rxd, sel_sts, sel_div;
    logic wr_txd, rd_rxd, rd_sts, wr_sts, wr_div;
    assign sel_txd = bus.Address == BASE_ADDR - 32'd8;
    assign sel_rxd = bus.Address == BASE_ADDR - 32'd4;
    assign sel_sts = bus.Address == BASE_ADDR;
    assign sel_div = bus.Address == BASE_ADDR + 32'd4;
    assign wr_txd  = bus.MemWrite & sel_txd;
    assign rd_rxd  = bus.MemRead  & sel_rxd;
    assign rd_sts  = bus.MemRead  & sel_sts;
    assign wr_sts  = bus.MemWrite & sel_sts;
    assign wr_div  = bus.MemWrite & sel_div;

    logic unused_wdata;
    assign unused_wdata = ^bus.Write_data[31:16];

    logic [15:0] div_q;
    logic        rxie_q, txie_q, rxovf_q, ferr_q, txovf_q, perr_flag;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_empty, tx_full, tx_pop, tx_push_ok;
    state_t        tx_state_q;

    assign tx_empty   = tx_cnt_q == '0;
    assign tx_full    = tx_cnt_q == CW'(FIFO_DEPTH);
    assign tx_pop     = (tx_state_q == S_IDLE) & ~tx_empty;
    assign tx_push_ok = wr_txd & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem_q[tx_wr_q] <= bus.Write_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)     tx_rd_q <= tx_rd_q + AW'(1);
            case ({tx_push_ok, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    logic [15:0] tx_div_q, tx_tick_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q, tx_last;
`ifdef UART_PARITY_EN
    logic        tx_par_q;
`endif
    assign tx_last = tx_tick_q == tx_div_q - 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_q       <= 1'b1;
            tx_div_q   <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!tx_empty) begin
                        tx_state_q <= S_START;
                        tx_q       <= 1'b0;
                        tx_div_q   <= div_q;
                        tx_tick_q  <= '0;
                        tx_shift_q <= tx_mem_q[tx_rd_q];
`ifdef UART_PARITY_EN
                        tx_par_q   <= ^tx_mem_q[tx_rd_q];
`endif
                    end
                end
                S_START: begin
                    tx_tick_q <= tx_tick_q + 16'd1;
                    if (tx_last) begin
                        tx_state_q <= S_DATA;
                        tx_tick_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end
                end
                S_DATA: begin
                    tx_tick_q <= tx_tick_q + 16'd1;
                    if (tx_last) begin
                        tx_tick_q <= '0;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_state_q <= S_PARITY;
                            tx_q       <= tx_par_q;
`else
                            tx_state_q <= S_STOP;
                            tx_q       <= 1'b1;
`endif
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_q       <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end
                end
                S_PARITY: begin
                    tx_tick_q <= tx_tick_q + 16'd1;
                    if (tx_last) begin
                        tx_state_q <= S_STOP;
                        tx_tick_q  <= '0;
                        tx_q       <= 1'b1;
                    end
                end
                S_STOP: begin
                    tx_tick_q <= tx_tick_q + 16'd1;
                    if (tx_last) tx_state_q <= S_IDLE;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX deserializer ----------------
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    state_t      rx_state_q;
    logic [15:0] rx_div_q, rx_tick_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_byte_q;
    logic        rx_push_q, rx_ferr_q, rx_last;
`ifdef UART_PARITY_EN
    logic        rx_par_q, rx_perr_q;
`endif
    assign rx_last = rx_tick_q == rx_div_q - 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
            rx_state_q <= S_IDLE;
            rx_div_q   <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            {rx_s3_q, rx_s2_q, rx_s1_q} <= {rx_s2_q, rx_s1_q, Rx_Serial};
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q <= 1'b0;
`endif
            rx_tick_q <= rx_tick_q + 16'd1;
            case (rx_state_q)
                S_IDLE: if (rx_s3_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_div_q   <= div_q;
                    rx_tick_q  <= '0;
                end
                // Half a bit after the edge: a high line here means a glitch, not a start bit.
                S_START: if (rx_tick_q == (rx_div_q >> 1)) begin
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    rx_tick_q  <= '0;
                    rx_bit_q   <= '0;
                end
                S_DATA: if (rx_last) begin
                    rx_tick_q  <= '0;
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                    if (rx_bit_q == 3'd7) rx_state_q <= S_PARITY;
`else
                    if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
`endif
                end
                S_PARITY: if (rx_last) begin
`ifdef UART_PARITY_EN
                    rx_par_q   <= rx_s2_q;
`endif
                    rx_tick_q  <= '0;
                    rx_state_q <= S_STOP;
                end
                S_STOP: if (rx_last) begin
                    rx_state_q <= S_IDLE;
                    rx_byte_q  <= rx_shift_q;
                    rx_push_q  <= rx_s2_q;
                    rx_ferr_q  <= ~rx_s2_q;
`ifdef UART_PARITY_EN
                    rx_perr_q  <= rx_s2_q & (rx_par_q != ^rx_shift_q);
`endif
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q;
    logic          rx_empty, rx_full, rx_pop, rx_push_ok;

    assign rx_empty   = rx_cnt_q == '0;
    assign rx_full    = rx_cnt_q == CW'(FIFO_DEPTH);
    assign rx_pop     = rd_rxd & ~rx_empty;
    assign rx_push_ok = rx_push_q & (~rx_full | rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem_q[rx_wr_q] <= rx_byte_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push_ok) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop)     rx_rd_q <= rx_rd_q + AW'(1);
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // ---------------- Control/status registers ----------------
    // Sticky flags: a set event on the clearing STATUS-read edge keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= 16'(CLKS_PER_BIT);
            rxie_q  <= 1'b0;
            txie_q  <= 1'b0;
            rxovf_q <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
        end else begin
            if (wr_div) div_q <= (bus.Write_data[15:0] < 16'd4) ? 16'd4 : bus.Write_data[15:0];
            if (wr_sts) {txie_q, rxie_q} <= bus.Write_data[9:8];
            rxovf_q <= (rx_push_q & ~rx_push_ok) | (rxovf_q & ~rd_sts);
            ferr_q  <= rx_ferr_q | (ferr_q & ~rd_sts);
            txovf_q <= (wr_txd & ~tx_push_ok) | (txovf_q & ~rd_sts);
        end
    end

`ifdef UART_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= rx_perr_q | (perr_q & ~rd_sts);
    end
    assign perr_flag = perr_q;
`else
    assign perr_flag = 1'b0;
`endif

    logic tx_active;
    assign tx_active = tx_state_q != S_IDLE;

    always_comb begin
        bus.Read_data = '0;
        if (sel_txd)
            bus.Read_data = 32'(tx_cnt_q);
        else if (sel_rxd)
            bus.Read_data = rx_empty ? 32'd0 : {24'b0, rx_mem_q[rx_rd_q]};
        else if (sel_sts)
            bus.Read_data = {22'b0, txie_q, rxie_q, perr_flag, txovf_q, ferr_q, rxovf_q,
                             tx_active, ~rx_empty, tx_full, tx_empty};
        else if (sel_div)
            bus.Read_data = {16'b0, div_q};
    end

    assign Tx_Serial  = tx_q;
    assign irq        = (rxie_q & ~rx_empty) | (txie_q & tx_empty & ~tx_active);
    assign tx_state_o = tx_state_q;
    assign rx_state_o = rx_state_q;
endmodule
